// File: rtl/hazard_scoreboard.sv
// Register hazard scoreboard: per-source forwarding select, load-use and
// long-latency stall detection, and a busy-register scoreboard for writers
// that have left the forwarding window.
module hazard_scoreboard #(
  parameter int unsigned NUM_SRC    = 2,
  parameter int unsigned NUM_STAGE  = 3,
  parameter int unsigned LOAD_STAGE = 2,
  parameter int unsigned REG_NUM    = 32,
  localparam int unsigned REG_W     = $clog2(REG_NUM),
  localparam int unsigned SEL_W     = $clog2(NUM_STAGE + 1)
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       id_valid,
  input  logic [NUM_SRC*REG_W-1:0]   id_rs,
  input  logic [NUM_SRC-1:0]         id_rs_used,
  input  logic [REG_W-1:0]           id_rd,
  input  logic                       id_wen,
  input  logic [NUM_STAGE-1:0]       stg_valid,
  input  logic [NUM_STAGE-1:0]       stg_wen,
  input  logic [NUM_STAGE-1:0]       stg_load,
  input  logic [NUM_STAGE*REG_W-1:0] stg_rd,
  input  logic                       wb_valid,
  input  logic [REG_W-1:0]           wb_rd,
  input  logic                       flush,
  output logic [NUM_SRC*SEL_W-1:0]   src_sel,
  output logic                       stall,
  output logic                       id_ready,
  output logic [REG_NUM-1:0]         busy_vec,
  output logic [31:0]                stall_cnt
);

  logic [NUM_SRC-1:0] src_stall;
  logic               issue;
  logic [REG_NUM-1:0] busy_nxt;

  for (genvar gi = 0; gi < NUM_SRC; gi++) begin : g_src
    logic [REG_W-1:0] rs;
    logic             src_on;
    logic             hit;
    logic             ld_hazard;
    logic [SEL_W-1:0] sel;

    assign rs     = id_rs[gi*REG_W +: REG_W];
    assign src_on = id_valid & id_rs_used[gi] & (rs != '0);

    // Scan oldest to youngest so the youngest matching stage wins.
    always_comb begin
      sel       = '0;
      hit       = 1'b0;
      ld_hazard = 1'b0;
      for (int k = int'(NUM_STAGE) - 1; k >= 0; k--) begin
        if (src_on && stg_valid[k] && stg_wen[k] &&
            (stg_rd[k*REG_W +: REG_W] == rs)) begin
          sel       = SEL_W'(k + 1);
          hit       = 1'b1;
          ld_hazard = stg_load[k] && (k < int'(LOAD_STAGE));
        end
      end
    end

    assign src_sel[gi*SEL_W +: SEL_W] = sel;
    // A busy register with no in-window writer means the result is still
    // being produced outside the forwarding network.
    assign src_stall[gi] = ld_hazard | (src_on & ~hit & busy_vec[rs]);
  end

  assign stall    = |src_stall;
  assign id_ready = ~stall;
  assign issue    = id_valid & id_ready;

  // Next scoreboard state: flush wipes everything, otherwise clear then set
  // so a younger writer overrides a same-cycle writeback.
  always_comb begin
    busy_nxt = busy_vec;
    if (flush) begin
      busy_nxt = '0;
    end else begin
      if (wb_valid && (wb_rd != '0)) busy_nxt[wb_rd] = 1'b0;
      if (issue && id_wen && (id_rd != '0)) busy_nxt[id_rd] = 1'b1;
    end
    busy_nxt[0] = 1'b0;
  end

  // Scoreboard register.
  always_ff @(posedge clock) begin
    if (reset) busy_vec <= '0;
    else       busy_vec <= busy_nxt;
  end

  // Saturating stall-cycle counter; survives flush.
  always_ff @(posedge clock) begin
    if (reset) begin
      stall_cnt <= '0;
    end else if (stall && id_valid && (stall_cnt != 32'hFFFF_FFFF)) begin
      stall_cnt <= stall_cnt + 32'd1;
    end
  end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed bench for hazard_scoreboard: forwarding select, load-use,
// long-latency scoreboard, flush, x0 and reset behaviour.
module tb_hazard_scoreboard;

  localparam int unsigned NUM_SRC    = 2;
  localparam int unsigned NUM_STAGE  = 3;
  localparam int unsigned LOAD_STAGE = 2;
  localparam int unsigned REG_NUM    = 32;
  localparam int unsigned REG_W      = 5;
  localparam int unsigned SEL_W      = 2;

  logic                       clock = 1'b0;
  logic                       reset;
  logic                       id_valid;
  logic [NUM_SRC*REG_W-1:0]   id_rs;
  logic [NUM_SRC-1:0]         id_rs_used;
  logic [REG_W-1:0]           id_rd;
  logic                       id_wen;
  logic [NUM_STAGE-1:0]       stg_valid;
  logic [NUM_STAGE-1:0]       stg_wen;
  logic [NUM_STAGE-1:0]       stg_load;
  logic [NUM_STAGE*REG_W-1:0] stg_rd;
  logic                       wb_valid;
  logic [REG_W-1:0]           wb_rd;
  logic                       flush;
  logic [NUM_SRC*SEL_W-1:0]   src_sel;
  logic                       stall;
  logic                       id_ready;
  logic [REG_NUM-1:0]         busy_vec;
  logic [31:0]                stall_cnt;

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [31:0] exp_cnt;

  hazard_scoreboard #(
    .NUM_SRC(NUM_SRC), .NUM_STAGE(NUM_STAGE),
    .LOAD_STAGE(LOAD_STAGE), .REG_NUM(REG_NUM)
  ) dut (
    .clock(clock), .reset(reset), .id_valid(id_valid), .id_rs(id_rs),
    .id_rs_used(id_rs_used), .id_rd(id_rd), .id_wen(id_wen),
    .stg_valid(stg_valid), .stg_wen(stg_wen), .stg_load(stg_load),
    .stg_rd(stg_rd), .wb_valid(wb_valid), .wb_rd(wb_rd), .flush(flush),
    .src_sel(src_sel), .stall(stall), .id_ready(id_ready),
    .busy_vec(busy_vec), .stall_cnt(stall_cnt)
  );

  always #5 clock = ~clock;

  task automatic clear_inputs();
    reset = 1'b0; id_valid = 1'b0; id_rs = '0; id_rs_used = '0;
    id_rd = '0; id_wen = 1'b0; stg_valid = '0; stg_wen = '0;
    stg_load = '0; stg_rd = '0; wb_valid = 1'b0; wb_rd = '0; flush = 1'b0;
  endtask

  task automatic set_stage(input int k, input int rd, input logic ld);
    stg_valid[k] = 1'b1;
    stg_wen[k]   = 1'b1;
    stg_load[k]  = ld;
    stg_rd[k*REG_W +: REG_W] = REG_W'(rd);
  endtask

  task automatic set_src(input int i, input int rs);
    id_valid = 1'b1;
    id_rs[i*REG_W +: REG_W] = REG_W'(rs);
    id_rs_used[i] = 1'b1;
  endtask

  // Advance one edge and land 1 time unit after it.
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  function automatic logic [SEL_W-1:0] sel_of(input int i);
    return src_sel[i*SEL_W +: SEL_W];
  endfunction

  task automatic test_reset();
    clear_inputs();
    reset = 1'b1;
    step();
    reset = 1'b0;
    #1;
    exp_cnt = 32'd0;
    n_checks++; if (busy_vec !== 32'h0) begin n_fail++; $display("FAIL reset_busy: got %h want %h", busy_vec, 32'h0); end
    n_checks++; if (stall_cnt !== exp_cnt) begin n_fail++; $display("FAIL reset_cnt: got %0d want %0d", stall_cnt, exp_cnt); end
    n_checks++; if (stall !== 1'b0 || id_ready !== 1'b1) begin n_fail++; $display("FAIL reset_stall: got stall=%b ready=%b want 0/1", stall, id_ready); end
    n_checks++; if (src_sel !== 4'h0) begin n_fail++; $display("FAIL reset_sel: got %h want 0", src_sel); end
  endtask

  task automatic test_ex_forward();
    clear_inputs();
    set_stage(0, 5, 1'b0);
    set_src(0, 5);
    #1;
    n_checks++; if (sel_of(0) !== 2'd1) begin n_fail++; $display("FAIL ex_fwd_sel: got %0d want 1", sel_of(0)); end
    n_checks++; if (stall !== 1'b0) begin n_fail++; $display("FAIL ex_fwd_stall: got %b want 0", stall); end
    // Invalid decode slot: no select, no stall.
    id_valid = 1'b0;
    stg_load[0] = 1'b1;
    #1;
    n_checks++; if (src_sel !== 4'h0 || stall !== 1'b0) begin n_fail++; $display("FAIL idle_outputs: got sel=%h stall=%b want 0/0", src_sel, stall); end
    step();
  endtask

  task automatic test_youngest();
    clear_inputs();
    set_stage(0, 7, 1'b0);
    set_stage(2, 7, 1'b0);
    set_src(1, 7);
    id_rs[0 +: REG_W] = REG_W'(7);
    #1;
    n_checks++; if (sel_of(1) !== 2'd1) begin n_fail++; $display("FAIL youngest_sel: got %0d want 1", sel_of(1)); end
    n_checks++; if (sel_of(0) !== 2'd0) begin n_fail++; $display("FAIL unused_src_sel: got %0d want 0", sel_of(0)); end
    stg_valid[0] = 1'b0;
    #1;
    n_checks++; if (sel_of(1) !== 2'd3) begin n_fail++; $display("FAIL older_sel: got %0d want 3", sel_of(1)); end
    // Younger non-load shadows an older load in stage 1.
    set_stage(0, 7, 1'b0);
    set_stage(1, 7, 1'b1);
    #1;
    n_checks++; if (stall !== 1'b0 || sel_of(1) !== 2'd1) begin n_fail++; $display("FAIL shadow_load: got stall=%b sel=%0d want 0/1", stall, sel_of(1)); end
    step();
  endtask

  task automatic test_load_use();
    clear_inputs();
    set_stage(0, 3, 1'b1);
    set_src(0, 3);
    #1;
    n_checks++; if (stall !== 1'b1 || id_ready !== 1'b0) begin n_fail++; $display("FAIL load_s0_stall: got stall=%b ready=%b want 1/0", stall, id_ready); end
    step();
    exp_cnt = exp_cnt + 32'd1;
    n_checks++; if (stall_cnt !== exp_cnt) begin n_fail++; $display("FAIL load_cnt1: got %0d want %0d", stall_cnt, exp_cnt); end
    stg_valid = '0; stg_load = '0;
    set_stage(1, 3, 1'b1);
    #1;
    n_checks++; if (stall !== 1'b1 || sel_of(0) !== 2'd2) begin n_fail++; $display("FAIL load_s1: got stall=%b sel=%0d want 1/2", stall, sel_of(0)); end
    step();
    exp_cnt = exp_cnt + 32'd1;
    n_checks++; if (stall_cnt !== exp_cnt) begin n_fail++; $display("FAIL load_cnt2: got %0d want %0d", stall_cnt, exp_cnt); end
    stg_valid = '0; stg_load = '0;
    set_stage(2, 3, 1'b1);
    #1;
    n_checks++; if (stall !== 1'b0 || sel_of(0) !== 2'd3) begin n_fail++; $display("FAIL load_s2: got stall=%b sel=%0d want 0/3", stall, sel_of(0)); end
    step();
    n_checks++; if (stall_cnt !== exp_cnt) begin n_fail++; $display("FAIL load_cnt_hold: got %0d want %0d", stall_cnt, exp_cnt); end
  endtask

  task automatic test_long_latency();
    clear_inputs();
    id_valid = 1'b1; id_wen = 1'b1; id_rd = REG_W'(9);
    step();
    n_checks++; if (busy_vec !== 32'h0000_0200) begin n_fail++; $display("FAIL ll_busy_set: got %h want %h", busy_vec, 32'h0000_0200); end
    clear_inputs();
    set_src(0, 9);
    #1;
    n_checks++; if (stall !== 1'b1 || sel_of(0) !== 2'd0) begin n_fail++; $display("FAIL ll_stall: got stall=%b sel=%0d want 1/0", stall, sel_of(0)); end
    // Writer back inside the window: forward instead of stalling.
    set_stage(1, 9, 1'b0);
    #1;
    n_checks++; if (stall !== 1'b0 || sel_of(0) !== 2'd2) begin n_fail++; $display("FAIL ll_in_window: got stall=%b sel=%0d want 0/2", stall, sel_of(0)); end
    // Stalled instruction must not mark its destination busy.
    stg_valid = '0;
    id_wen = 1'b1; id_rd = REG_W'(12);
    wb_valid = 1'b1; wb_rd = REG_W'(9);
    step();
    exp_cnt = exp_cnt + 32'd1;
    wb_valid = 1'b0; id_wen = 1'b0;
    #1;
    n_checks++; if (busy_vec !== 32'h0) begin n_fail++; $display("FAIL ll_wb_clear: got %h want 0", busy_vec); end
    n_checks++; if (stall !== 1'b0 || sel_of(0) !== 2'd0) begin n_fail++; $display("FAIL ll_after_wb: got stall=%b sel=%0d want 0/0", stall, sel_of(0)); end
    n_checks++; if (stall_cnt !== exp_cnt) begin n_fail++; $display("FAIL ll_cnt: got %0d want %0d", stall_cnt, exp_cnt); end
  endtask

  task automatic test_set_clear_flush();
    clear_inputs();
    id_valid = 1'b1; id_wen = 1'b1; id_rd = REG_W'(9);
    step();
    id_rd = REG_W'(4);
    wb_valid = 1'b1; wb_rd = REG_W'(4);
    step();
    n_checks++; if (busy_vec !== 32'h0000_0210) begin n_fail++; $display("FAIL set_wins: got %h want %h", busy_vec, 32'h0000_0210); end
    // Flush cycle: issue and wb ignored, combinational outputs still live.
    clear_inputs();
    flush = 1'b1;
    set_stage(0, 5, 1'b0);
    set_src(0, 5);
    id_wen = 1'b1; id_rd = REG_W'(6);
    wb_valid = 1'b1; wb_rd = REG_W'(9);
    #1;
    n_checks++; if (sel_of(0) !== 2'd1 || stall !== 1'b0) begin n_fail++; $display("FAIL flush_comb: got sel=%0d stall=%b want 1/0", sel_of(0), stall); end
    step();
    n_checks++; if (busy_vec !== 32'h0) begin n_fail++; $display("FAIL flush_busy: got %h want 0", busy_vec); end
    n_checks++; if (stall_cnt !== exp_cnt) begin n_fail++; $display("FAIL flush_cnt: got %0d want %0d", stall_cnt, exp_cnt); end
  endtask

  task automatic test_x0();
    clear_inputs();
    set_stage(0, 0, 1'b1);
    set_src(0, 0);
    id_wen = 1'b1; id_rd = '0;
    #1;
    n_checks++; if (src_sel !== 4'h0 || stall !== 1'b0) begin n_fail++; $display("FAIL x0_comb: got sel=%h stall=%b want 0/0", src_sel, stall); end
    step();
    n_checks++; if (busy_vec !== 32'h0) begin n_fail++; $display("FAIL x0_busy: got %h want 0", busy_vec); end
  endtask

  task automatic test_reset_mid();
    clear_inputs();
    id_valid = 1'b1; id_wen = 1'b1; id_rd = REG_W'(11);
    step();
    n_checks++; if (busy_vec !== 32'h0000_0800) begin n_fail++; $display("FAIL mid_busy_set: got %h want %h", busy_vec, 32'h0000_0800); end
    // Reset beats a stalling source, an issue and a flush in the same cycle.
    clear_inputs();
    reset = 1'b1; flush = 1'b1;
    set_src(0, 11);
    set_stage(0, 5, 1'b0);
    set_src(1, 5);
    id_wen = 1'b1; id_rd = REG_W'(13);
    #1;
    n_checks++; if (stall !== 1'b1 || sel_of(1) !== 2'd1) begin n_fail++; $display("FAIL mid_comb: got stall=%b sel1=%0d want 1/1", stall, sel_of(1)); end
    step();
    exp_cnt = 32'd0;
    n_checks++; if (busy_vec !== 32'h0) begin n_fail++; $display("FAIL mid_busy: got %h want 0", busy_vec); end
    n_checks++; if (stall_cnt !== exp_cnt) begin n_fail++; $display("FAIL mid_cnt: got %0d want %0d", stall_cnt, exp_cnt); end
    clear_inputs();
    step();
  endtask

  initial begin
    clear_inputs();
    exp_cnt = 32'd0;
    test_reset();
    test_ex_forward();
    test_youngest();
    test_load_use();
    test_long_latency();
    test_set_clear_flush();
    test_x0();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/hazard_scoreboard.md
HAZARD_SCOREBOARD -- requirements
Module: hazard_scoreboard

Interface
REQ-001 SHALL have parameter NUM_SRC, default 2, meaning number of decode source operands checked per cycle.
REQ-002 SHALL have parameter NUM_STAGE, default 3, meaning number of forwarding stages; stage 0 is the youngest (EXU).
REQ-003 SHALL have parameter LOAD_STAGE, default 2, meaning the first stage index at which load data is forwardable.
REQ-004 SHALL have parameter REG_NUM, default 32, meaning number of architectural registers; REG_W = $clog2(REG_NUM); SEL_W = $clog2(NUM_STAGE+1).
REQ-005 SHALL use one clock and a synchronous, active-high reset; all state updates on the rising edge of clock.
REQ-006 clock  in  1  system clock.
REQ-007 reset  in  1  synchronous active-high reset.
REQ-008 id_valid  in  1  decode slot holds a valid instruction.
REQ-009 id_rs  in  NUM_SRC*REG_W  source register indices; source i occupies bits [i*REG_W +: REG_W].
REQ-010 id_rs_used  in  NUM_SRC  source i is read by the instruction.
REQ-011 id_rd, id_wen  in  REG_W, 1  destination register and register-write enable.
REQ-012 stg_valid, stg_wen, stg_load  in  NUM_STAGE each  per-stage valid, register-write enable, and load flags.
REQ-013 stg_rd  in  NUM_STAGE*REG_W  per-stage destination index, packed as id_rs.
REQ-014 wb_valid, wb_rd  in  1, REG_W  register-file write this cycle.
REQ-015 flush  in  1  squash all in-flight instructions.
REQ-016 src_sel  out  NUM_SRC*SEL_W  per-source select: 0 = register file, k+1 = stage k.
REQ-017 stall, id_ready  out  1, 1  decode must hold; id_ready = ~stall.
REQ-018 busy_vec  out  REG_NUM  scoreboard state, registered.
REQ-019 stall_cnt  out  32  saturating count of stall cycles, registered.

Function
REQ-020 Define issue = id_valid & id_ready.
REQ-021 A stage k matches source i when all of the following hold: stg_valid[k], stg_wen[k], stg_rd[k] == rs_i, rs_i != 0, id_valid, and id_rs_used[i].
REQ-022 src_sel for source i SHALL be k+1 for the lowest-numbered (youngest) matching k, or 0 if no stage matches; the output is combinational with zero latency.
REQ-023 Load-use: if the youngest match k has stg_load[k]=1 and k < LOAD_STAGE, stall SHALL be 1 for that source.
REQ-024 Long-latency: if busy_vec[rs_i]=1 and no stage matches source i, stall SHALL be 1, because the writer is outside the forwarding window.
REQ-025 stall SHALL be the OR of the stall conditions over all sources; an unused source or rs=0 never causes a stall.
REQ-026 On issue with id_wen=1 and id_rd!=0, busy_vec[id_rd] SHALL be set at the next edge.
REQ-027 On wb_valid with wb_rd!=0, busy_vec[wb_rd] SHALL be cleared at the next edge.
REQ-028 If the same register is set and cleared in the same cycle, set SHALL win because the new writer is younger.
REQ-029 busy_vec[0] SHALL always be 0.
REQ-030 A flush SHALL clear all busy bits at the next edge; when flush is 1, issue-set and wb-clear in that cycle are ignored.
REQ-031 Outputs driven in a flush cycle SHALL remain computed normally, since they are combinational.
REQ-032 stall_cnt SHALL increment when stall & id_valid and saturate at 32'hFFFF_FFFF; it is not cleared by flush.
REQ-033 With id_valid=0, stall SHALL be 0 and all src_sel values SHALL be 0.

Reset
REQ-034 While reset is 1 at an edge, busy_vec SHALL be 0 and stall_cnt SHALL be 0 after the edge.
REQ-035 Reset SHALL take priority over flush, issue, and wb.
REQ-036 Reset asserted mid-operation SHALL discard all pending busy bits; combinational outputs SHALL follow the inputs in the same cycle.

Verification
REQ-037 EX forward: stage0 {valid,wen,rd=5,load=0}, id rs0=5 -> src_sel[0]=1, stall=0.
REQ-038 Youngest wins: stage0 rd=7 and stage2 rd=7, rs1=7 -> src_sel[1]=1.
REQ-039 Load-use: stage0 load rd=3, rs0=3 -> stall=1, stall_cnt +1 per cycle. Next cycle the load is in stage1: stall=1. When it reaches stage2: stall=0, src_sel[0]=3.
REQ-040 Long-latency: issue rd=9, then stages empty, rs0=9 -> stall=1. wb_rd=9 -> next cycle busy_vec[9]=0, stall=0, src_sel[0]=0.
REQ-041 Same-cycle set/clear: issue rd=4 with wb_rd=4 -> busy_vec[4]=1 after the edge. Flush with busy bits {4,9} -> busy_vec=0.
REQ-042 x0 and reset: stage0 rd=0 and rs0=0 -> src_sel=0, stall=0. Reset after busy bits are set -> busy_vec=0 and stall_cnt=0.
